// File: rtl/sisc_mem_pkg.sv
// Shared types and constants for the SISC memory arbiter.
package sisc_mem_pkg;

  // Width of the wait-state and streak counters.
  localparam int CNT_W = 4;

  // Counter increment step.
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Arbiter sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Which requester owns the access in flight.
  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  // Increment that sticks at the given limit.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val,
                                               input logic [CNT_W-1:0] limit);
    logic [CNT_W-1:0] res;
    if (val >= limit) begin
      res = limit;
    end else begin
      res = val + CNT_ONE;
    end
    return res;
  endfunction

endpackage

// File: rtl/sisc_mem_arb_pick.sv
// Combinational winner selection: data first, unless the fetch port has
// waited out a full streak of data grants.
module sisc_mem_arb_pick
  import sisc_mem_pkg::*;
#(
  parameter int MAX_STREAK = 3
) (
  input  logic             if_req,
  input  logic             dm_req,
  input  logic [CNT_W-1:0] streak,
  output owner_e           owner,
  output logic             valid
);

  localparam logic [CNT_W-1:0] STREAK_LIM = CNT_W'(MAX_STREAK);

  logic fetch_starved_s;

  // Choose the owner of the next access and flag whether anyone is asking.
  always_comb begin
    owner           = OWN_IF;
    valid           = 1'b0;
    fetch_starved_s = if_req && (streak == STREAK_LIM);
    if (dm_req && !fetch_starved_s) begin
      owner = OWN_DM;
      valid = 1'b1;
    end else if (if_req) begin
      owner = OWN_IF;
      valid = 1'b1;
    end else begin
      owner = OWN_IF;
      valid = 1'b0;
    end
  end

endmodule

// File: rtl/sisc_mem_arb.sv
// Single-port memory arbiter/sequencer for the SISC fetch and data ports.
// Each access holds mem_en for WAIT_CYC cycles, then pulses done once.
module sisc_mem_arb
  import sisc_mem_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 32,
  parameter int WAIT_CYC   = 2,
  parameter int MAX_STREAK = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_gnt,
  output logic              dm_done,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(WAIT_CYC - 1);
  localparam logic [CNT_W-1:0] STREAK_LIM = CNT_W'(MAX_STREAK);

  generate
    if (WAIT_CYC < 1 || WAIT_CYC > 15) begin : g_bad_wait
      $error("sisc_mem_arb: WAIT_CYC must be in 1..15");
    end
    if (MAX_STREAK < 0 || MAX_STREAK > 15) begin : g_bad_streak
      $error("sisc_mem_arb: MAX_STREAK must be in 0..15");
    end
  endgenerate

  state_e            state_r,    state_nxt_s;
  owner_e            owner_r,    owner_nxt_s;
  logic [CNT_W-1:0]  cnt_r,      cnt_nxt_s;
  logic [CNT_W-1:0]  streak_r,   streak_nxt_s;
  logic [ADDR_W-1:0] addr_r,     addr_nxt_s;
  logic              we_r,       we_nxt_s;
  logic [DATA_W-1:0] wdata_r,    wdata_nxt_s;
  logic [DATA_W-1:0] if_rdata_r, if_rdata_nxt_s;
  logic [DATA_W-1:0] dm_rdata_r, dm_rdata_nxt_s;
  logic              if_gnt_r,   if_gnt_nxt_s;
  logic              dm_gnt_r,   dm_gnt_nxt_s;
  owner_e            pick_owner_s;
  logic              pick_valid_s;

  sisc_mem_arb_pick #(
    .MAX_STREAK(MAX_STREAK)
  ) u_pick (
    .if_req(if_req),
    .dm_req(dm_req),
    .streak(streak_r),
    .owner (pick_owner_s),
    .valid (pick_valid_s)
  );

  // Next-state, latch and capture decisions for the IDLE/ACCESS/DONE sequence.
  always_comb begin
    state_nxt_s    = state_r;
    owner_nxt_s    = owner_r;
    cnt_nxt_s      = cnt_r;
    streak_nxt_s   = streak_r;
    addr_nxt_s     = addr_r;
    we_nxt_s       = we_r;
    wdata_nxt_s    = wdata_r;
    if_rdata_nxt_s = if_rdata_r;
    dm_rdata_nxt_s = dm_rdata_r;
    if_gnt_nxt_s   = 1'b0;
    dm_gnt_nxt_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pick_valid_s) begin
          state_nxt_s = ST_ACCESS;
          owner_nxt_s = pick_owner_s;
          cnt_nxt_s   = {CNT_W{1'b0}};
          if (pick_owner_s == OWN_DM) begin
            addr_nxt_s   = dm_addr;
            we_nxt_s     = dm_we;
            wdata_nxt_s  = dm_wdata;
            dm_gnt_nxt_s = 1'b1;
            // Only grants that bypass a waiting fetch lengthen the streak.
            if (if_req) begin
              streak_nxt_s = sat_inc(streak_r, STREAK_LIM);
            end else begin
              streak_nxt_s = {CNT_W{1'b0}};
            end
          end else begin
            addr_nxt_s   = if_addr;
            we_nxt_s     = 1'b0;
            wdata_nxt_s  = {DATA_W{1'b0}};
            if_gnt_nxt_s = 1'b1;
            streak_nxt_s = {CNT_W{1'b0}};
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        cnt_nxt_s = cnt_r + CNT_ONE;
        if (cnt_r == WAIT_LAST) begin
          state_nxt_s = ST_DONE;
          // Read data is only valid in the last cycle; stores leave rdata alone.
          if (owner_r == OWN_IF) begin
            if_rdata_nxt_s = mem_rdata;
          end else if (!we_r) begin
            dm_rdata_nxt_s = mem_rdata;
          end else begin
            dm_rdata_nxt_s = dm_rdata_r;
          end
        end else begin
          state_nxt_s = ST_ACCESS;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Sequencer state, wait counter, streak and grant pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      owner_r  <= OWN_IF;
      cnt_r    <= {CNT_W{1'b0}};
      streak_r <= {CNT_W{1'b0}};
      if_gnt_r <= 1'b0;
      dm_gnt_r <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      owner_r  <= owner_nxt_s;
      cnt_r    <= cnt_nxt_s;
      streak_r <= streak_nxt_s;
      if_gnt_r <= if_gnt_nxt_s;
      dm_gnt_r <= dm_gnt_nxt_s;
    end
  end

  // Access parameters latched at grant and per-port read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_r     <= {ADDR_W{1'b0}};
      we_r       <= 1'b0;
      wdata_r    <= {DATA_W{1'b0}};
      if_rdata_r <= {DATA_W{1'b0}};
      dm_rdata_r <= {DATA_W{1'b0}};
    end else begin
      addr_r     <= addr_nxt_s;
      we_r       <= we_nxt_s;
      wdata_r    <= wdata_nxt_s;
      if_rdata_r <= if_rdata_nxt_s;
      dm_rdata_r <= dm_rdata_nxt_s;
    end
  end

  assign if_gnt    = if_gnt_r;
  assign dm_gnt    = dm_gnt_r;
  assign if_done   = (state_r == ST_DONE) && (owner_r == OWN_IF);
  assign dm_done   = (state_r == ST_DONE) && (owner_r == OWN_DM);
  assign if_rdata  = if_rdata_r;
  assign dm_rdata  = dm_rdata_r;
  assign mem_en    = (state_r == ST_ACCESS);
  assign mem_we    = (state_r == ST_ACCESS) && we_r;
  assign mem_addr  = addr_r;
  assign mem_wdata = wdata_r;
  assign busy      = (state_r != ST_IDLE);

endmodule

// File: tb/tb_sisc_mem_arb.sv
// Scenario bench for sisc_mem_arb with per-port scoreboards.
module tb_sisc_mem_arb;

  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 32;
  localparam int WAIT_CYC   = 2;
  localparam int MAX_STREAK = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt, if_done;
  logic [DATA_W-1:0] if_rdata;
  logic              dm_req, dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_gnt, dm_done;
  logic [DATA_W-1:0] dm_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [31:0] if_q[$];
  logic [31:0] dm_q[$];
  logic        gnt_q[$];   // 1 = data grant expected, 0 = fetch grant expected

  bit   if_hold = 1'b0;
  bit   dm_hold = 1'b0;
  logic if_done_s = 1'b0;
  logic dm_done_s = 1'b0;
  logic [31:0] last_if_exp = 32'h0;
  logic [31:0] last_dm_exp = 32'h0;

  always #5 clk = ~clk;

  sisc_mem_arb #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_CYC(WAIT_CYC), .MAX_STREAK(MAX_STREAK)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_done(if_done), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_done(dm_done), .dm_rdata(dm_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // Memory contents: fixed instruction at 0x0004, address-derived pattern elsewhere.
  function automatic logic [31:0] mem_model(input logic [15:0] a);
    if (a == 16'h0004) return 32'h10A0_0003;
    return {a ^ 16'h5A5A, a};
  endfunction

  assign mem_rdata = mem_en ? mem_model(mem_addr) : 32'h0;

  // One clock: requesters drop req at the edge ending their done cycle, then sample mid-cycle.
  task automatic clk_cycle();
    @(posedge clk);
    #1;
    if (if_done_s && !if_hold) if_req = 1'b0;
    if (dm_done_s && !dm_hold) dm_req = 1'b0;
    @(negedge clk);
    if_done_s = if_done;
    dm_done_s = dm_done;
    cyc++;
  endtask

  task automatic test_reset();
    logic [31:0] exp32;
    repeat (2) @(negedge clk);
    n_assert++;
    if ({mem_en, mem_we, if_gnt, dm_gnt, if_done, dm_done, busy} !== 7'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b, expected 0000000",
               {mem_en, mem_we, if_gnt, dm_gnt, if_done, dm_done, busy});
    end
    n_assert++;
    if (if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_rdata: got if=%h dm=%h, expected 0", if_rdata, dm_rdata);
    end
    n_assert++;
    if (mem_addr !== 16'h0 || mem_wdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mem_bus: got addr=%h wdata=%h, expected 0", mem_addr, mem_wdata);
    end
    if_q.push_back(32'h10A0_0003);
    rst = 1'b0;
    clk_cycle();  // cycle 1
    n_assert++;
    if ({if_gnt, dm_gnt, mem_en, mem_we, busy} !== 5'b10101 || mem_addr !== 16'h0004) begin
      n_fail++;
      $display("FAIL fetch_c1: got gnt/dgnt/en/we/busy=%b addr=%h, expected 10101 addr=0004",
               {if_gnt, dm_gnt, mem_en, mem_we, busy}, mem_addr);
    end
    clk_cycle();  // cycle 2
    n_assert++;
    if ({if_gnt, mem_en, if_done} !== 3'b010) begin
      n_fail++;
      $display("FAIL fetch_c2: got gnt/en/done=%b, expected 010", {if_gnt, mem_en, if_done});
    end
    clk_cycle();  // cycle 3
    n_assert++;
    if ({if_done, dm_done, mem_en} !== 3'b100) begin
      n_fail++;
      $display("FAIL fetch_c3: got done/ddone/en=%b, expected 100", {if_done, dm_done, mem_en});
    end
    exp32 = (if_q.size() != 0) ? if_q.pop_front() : 32'hxxxx_xxxx;
    n_assert++;
    if (if_rdata !== exp32) begin
      n_fail++;
      $display("FAIL fetch_rdata: got %h, expected %h", if_rdata, exp32);
    end
    last_if_exp = 32'h10A0_0003;
    clk_cycle();  // cycle 4: finished request is not re-granted
    n_assert++;
    if ({busy, if_gnt} !== 2'b00) begin
      n_fail++;
      $display("FAIL fetch_idle: got busy/gnt=%b, expected 00", {busy, if_gnt});
    end
  endtask

  task automatic test_priority();
    int   dm_done_cyc = -1;
    int   if_gnt_cyc  = -1;
    bit   both = 1'b0;
    logic expb;
    logic [31:0] exp32;
    gnt_q.push_back(1'b1);
    gnt_q.push_back(1'b0);
    dm_q.push_back(mem_model(16'h0020));
    if_q.push_back(mem_model(16'h0008));
    dm_we = 1'b0; dm_addr = 16'h0020; dm_req = 1'b1;
    if_addr = 16'h0008; if_req = 1'b1;
    for (int c = 0; c < 30; c++) begin
      clk_cycle();
      if ((if_gnt && dm_gnt) || (if_done && dm_done)) both = 1'b1;
      if (if_gnt || dm_gnt) begin
        expb = (gnt_q.size() != 0) ? gnt_q.pop_front() : 1'bx;
        n_assert++;
        if (dm_gnt !== expb) begin
          n_fail++;
          $display("FAIL prio_order: got dm_gnt=%b, expected %b", dm_gnt, expb);
        end
      end
      if (if_gnt) if_gnt_cyc = cyc;
      if (dm_done) begin
        dm_done_cyc = cyc;
        exp32 = (dm_q.size() != 0) ? dm_q.pop_front() : 32'hxxxx_xxxx;
        n_assert++;
        if (dm_rdata !== exp32) begin
          n_fail++;
          $display("FAIL prio_dm_rdata: got %h, expected %h", dm_rdata, exp32);
        end
      end
      if (if_done) begin
        exp32 = (if_q.size() != 0) ? if_q.pop_front() : 32'hxxxx_xxxx;
        n_assert++;
        if (if_rdata !== exp32) begin
          n_fail++;
          $display("FAIL prio_if_rdata: got %h, expected %h", if_rdata, exp32);
        end
      end
      if (gnt_q.size() == 0 && dm_q.size() == 0 && if_q.size() == 0 && !busy) break;
    end
    n_assert++;
    if (dm_done_cyc < 0 || if_gnt_cyc != dm_done_cyc + 2) begin
      n_fail++;
      $display("FAIL prio_fetch_after: got if_gnt cycle %0d, expected %0d", if_gnt_cyc, dm_done_cyc + 2);
    end
    n_assert++;
    if (both || gnt_q.size() != 0 || dm_q.size() != 0 || if_q.size() != 0) begin
      n_fail++;
      $display("FAIL prio_complete: got overlap=%0d pending=%0d, expected 0 0",
               both, gnt_q.size() + dm_q.size() + if_q.size());
    end
    gnt_q.delete(); dm_q.delete(); if_q.delete();
    last_dm_exp = mem_model(16'h0020);
    last_if_exp = mem_model(16'h0008);
  endtask

  task automatic test_store();
    dm_q.push_back(last_dm_exp);
    dm_we = 1'b1; dm_addr = 16'h0030; dm_wdata = 32'hDEAD_BEEF; dm_req = 1'b1;
    clk_cycle();  // cycle 1
    n_assert++;
    if (dm_gnt !== 1'b1) begin
      n_fail++;
      $display("FAIL store_gnt: got %b, expected 1", dm_gnt);
    end
    dm_addr = 16'h0031; dm_wdata = 32'h0;  // requester moves on after grant
    for (int c = 1; c <= 2; c++) begin
      n_assert++;
      if ({mem_en, mem_we} !== 2'b11 || mem_addr !== 16'h0030 || mem_wdata !== 32'hDEAD_BEEF) begin
        n_fail++;
        $display("FAIL store_bus_c%0d: got en/we=%b addr=%h data=%h, expected 11 0030 deadbeef",
                 c, {mem_en, mem_we}, mem_addr, mem_wdata);
      end
      clk_cycle();
    end
    n_assert++;
    if ({dm_done, mem_en, mem_we} !== 3'b100) begin
      n_fail++;
      $display("FAIL store_done: got done/en/we=%b, expected 100", {dm_done, mem_en, mem_we});
    end
    n_assert++;
    if (dm_rdata !== dm_q.pop_front() || if_rdata !== last_if_exp) begin
      n_fail++;
      $display("FAIL store_rdata_kept: got dm=%h if=%h, expected dm=%h if=%h",
               dm_rdata, if_rdata, last_dm_exp, last_if_exp);
    end
    clk_cycle();
    dm_we = 1'b0;
  endtask

  task automatic test_streak();
    int   fg = 0;
    int   prev_g = -1;
    bit   both = 1'b0;
    logic expb;
    logic [31:0] exp32;
    logic seq [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 9; i++) gnt_q.push_back(seq[i]);
    for (int i = 0; i < 7; i++) dm_q.push_back(mem_model(16'h0024));
    for (int i = 0; i < 2; i++) if_q.push_back(mem_model(16'h000C));
    dm_hold = 1'b1; if_hold = 1'b1;
    dm_we = 1'b0; dm_addr = 16'h0024; dm_req = 1'b1;
    if_addr = 16'h000C; if_req = 1'b1;
    for (int c = 0; c < 80; c++) begin
      clk_cycle();
      if ((if_gnt && dm_gnt) || (if_done && dm_done)) both = 1'b1;
      if (if_gnt || dm_gnt) begin
        expb = (gnt_q.size() != 0) ? gnt_q.pop_front() : 1'bx;
        n_assert++;
        if (dm_gnt !== expb) begin
          n_fail++;
          $display("FAIL streak_order: got dm_gnt=%b, expected %b at cycle %0d", dm_gnt, expb, cyc);
        end
        if (prev_g >= 0) begin
          n_assert++;
          if (cyc - prev_g != WAIT_CYC + 2) begin
            n_fail++;
            $display("FAIL streak_period: got %0d, expected %0d", cyc - prev_g, WAIT_CYC + 2);
          end
        end
        prev_g = cyc;
        if (if_gnt) begin
          fg++;
          if (fg == 2) if_hold = 1'b0;
        end
        if (gnt_q.size() == 0) dm_hold = 1'b0;
      end
      if (dm_done) begin
        exp32 = (dm_q.size() != 0) ? dm_q.pop_front() : 32'hxxxx_xxxx;
        n_assert++;
        if (dm_rdata !== exp32) begin
          n_fail++;
          $display("FAIL streak_dm_rdata: got %h, expected %h", dm_rdata, exp32);
        end
      end
      if (if_done) begin
        exp32 = (if_q.size() != 0) ? if_q.pop_front() : 32'hxxxx_xxxx;
        n_assert++;
        if (if_rdata !== exp32) begin
          n_fail++;
          $display("FAIL streak_if_rdata: got %h, expected %h", if_rdata, exp32);
        end
      end
      if (gnt_q.size() == 0 && dm_q.size() == 0 && if_q.size() == 0 && !busy) break;
    end
    n_assert++;
    if (both || gnt_q.size() != 0 || dm_q.size() != 0 || if_q.size() != 0 || busy) begin
      n_fail++;
      $display("FAIL streak_complete: got overlap=%0d pending=%0d busy=%b, expected 0 0 0",
               both, gnt_q.size() + dm_q.size() + if_q.size(), busy);
    end
    gnt_q.delete(); dm_q.delete(); if_q.delete();
    dm_hold = 1'b0; if_hold = 1'b0;
    last_dm_exp = mem_model(16'h0024);
    last_if_exp = mem_model(16'h000C);
  endtask

  task automatic test_reset_mid();
    int lat = 0;
    dm_q.push_back(mem_model(16'h0028));
    dm_we = 1'b0; dm_addr = 16'h0028; dm_req = 1'b1;
    clk_cycle();  // cycle 1
    clk_cycle();  // cycle 2: second ACCESS cycle
    n_assert++;
    if (mem_en !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_access: got mem_en=%b, expected 1", mem_en);
    end
    rst = 1'b1;
    #1;
    n_assert++;
    if ({mem_en, mem_we, if_gnt, dm_gnt, if_done, dm_done, busy} !== 7'b0 ||
        mem_addr !== 16'h0 || if_rdata !== 32'h0 || dm_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got ctrl=%b addr=%h if=%h dm=%h, expected all 0",
               {mem_en, mem_we, if_gnt, dm_gnt, if_done, dm_done, busy}, mem_addr, if_rdata, dm_rdata);
    end
    @(negedge clk);
    n_assert++;
    if (dm_done !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_no_done: got %b, expected 0", dm_done);
    end
    rst = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      clk_cycle();
      if (c == 1) begin
        n_assert++;
        if (dm_gnt !== 1'b1) begin
          n_fail++;
          $display("FAIL rstmid_regrant: got %b, expected 1", dm_gnt);
        end
      end
      if (dm_done) begin
        lat = c;
        n_assert++;
        if (dm_rdata !== dm_q.pop_front()) begin
          n_fail++;
          $display("FAIL rstmid_rdata: got %h, expected %h", dm_rdata, mem_model(16'h0028));
        end
        break;
      end
    end
    n_assert++;
    if (lat != WAIT_CYC + 1) begin
      n_fail++;
      $display("FAIL rstmid_latency: got %0d, expected %0d", lat, WAIT_CYC + 1);
    end
    dm_q.delete();
    clk_cycle();
    last_dm_exp = mem_model(16'h0028);
    last_if_exp = 32'h0;
  endtask

  task automatic test_addr_latch();
    dm_q.push_back(mem_model(16'h0040));
    dm_we = 1'b0; dm_addr = 16'h0040; dm_req = 1'b1;
    clk_cycle();  // cycle 1
    n_assert++;
    if (dm_gnt !== 1'b1 || mem_addr !== 16'h0040) begin
      n_fail++;
      $display("FAIL latch_c1: got gnt=%b addr=%h, expected 1 0040", dm_gnt, mem_addr);
    end
    dm_addr = 16'h0050;
    clk_cycle();  // cycle 2
    n_assert++;
    if (mem_en !== 1'b1 || mem_addr !== 16'h0040) begin
      n_fail++;
      $display("FAIL latch_c2: got en=%b addr=%h, expected 1 0040", mem_en, mem_addr);
    end
    clk_cycle();  // cycle 3
    n_assert++;
    if (dm_done !== 1'b1 || dm_rdata !== dm_q.pop_front() || if_rdata !== last_if_exp) begin
      n_fail++;
      $display("FAIL latch_done: got done=%b dm=%h if=%h, expected 1 %h %h",
               dm_done, dm_rdata, if_rdata, mem_model(16'h0040), last_if_exp);
    end
    dm_q.delete();
    clk_cycle();
  endtask

  initial begin
    rst = 1'b1;
    if_req = 1'b1; if_addr = 16'h0004;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = 16'h0; dm_wdata = 32'h0;
    test_reset();
    test_priority();
    test_store();
    test_streak();
    test_reset_mid();
    test_addr_latch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
